// File: rtl/apb_arbiter_rr.sv
// N-master to 1-slave APB arbiter: round-robin grant, SETUP/ACCESS sequencing
// toward the shared slave, and a per-transfer ACCESS timeout that forces an error response.

module apb_arbiter_rr_lane #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sel,
    input  logic                  done,
    input  logic                  tmo,
    input  logic [DATA_WIDTH-1:0] s_prdata,
    input  logic                  s_pslverr,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr
);
    logic hit;

    assign hit     = sel & done;
    assign pready  = hit;
    assign pslverr = hit & (tmo | s_pslverr);
    // a forced completion never forwards whatever the slave happens to drive
    assign prdata  = (hit && !tmo) ? s_prdata : '0;
endmodule

module apb_arbiter_rr #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int IDX_W         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int STRB_W        = DATA_WIDTH / 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_psel,
    input  logic [NUM_MASTERS-1:0]            m_penable,
    input  logic [NUM_MASTERS-1:0]            m_pwrite,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_paddr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_pwdata,
    input  logic [NUM_MASTERS*STRB_W-1:0]     m_pstrb,
    input  logic [NUM_MASTERS*3-1:0]          m_pprot,
    output logic [NUM_MASTERS-1:0]            m_pready,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_prdata,
    output logic [NUM_MASTERS-1:0]            m_pslverr,
    output logic                              s_psel,
    output logic                              s_penable,
    output logic                              s_pwrite,
    output logic [ADDR_WIDTH-1:0]             s_paddr,
    output logic [DATA_WIDTH-1:0]             s_pwdata,
    output logic [STRB_W-1:0]                 s_pstrb,
    output logic [2:0]                        s_pprot,
    input  logic                              s_pready,
    input  logic                              s_pslverr,
    input  logic [DATA_WIDTH-1:0]             s_prdata,
    output logic [IDX_W-1:0]                  grant_idx,
    output logic                              busy,
    output logic                              timeout_err
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);
    localparam logic [IDX_W:0]   N_EXT    = (IDX_W+1)'(NUM_MASTERS);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       rr_ptr, ptr_nxt, off, winner;
    logic [IDX_W:0]         sum;
    logic [2*NUM_MASTERS-1:0] req_dbl;
    logic [NUM_MASTERS-1:0] req_rot;
    logic                   found, tmo_hit, done;
    logic [CNT_W-1:0]       tmo_cnt;
    logic                   unused_penable;

    logic [ADDR_WIDTH-1:0]  paddr_a  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  pwdata_a [NUM_MASTERS];
    logic [STRB_W-1:0]      pstrb_a  [NUM_MASTERS];
    logic [2:0]             pprot_a  [NUM_MASTERS];

    assign unused_penable = ^m_penable;

    // Rotate requests so bit 0 is the master just after rr_ptr; lowest set bit wins.
    always_comb begin
        ptr_nxt = (rr_ptr == LAST_IDX) ? '0 : rr_ptr + IDX_W'(1);
        req_dbl = {m_psel, m_psel};
        req_rot = NUM_MASTERS'(req_dbl >> ptr_nxt);
        found   = |req_rot;
        off     = '0;
        for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
            if (req_rot[j]) off = IDX_W'(j);
        end
        sum    = {1'b0, ptr_nxt} + {1'b0, off};
        winner = (sum >= N_EXT) ? IDX_W'(sum - N_EXT) : IDX_W'(sum);
    end

    assign tmo_hit = (TIMEOUT_CYCLES > 0) && (state == ACCESS) && !s_pready
                     && (tmo_cnt == TMO_LAST);
    assign done    = (state == ACCESS) && (s_pready || tmo_hit);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= LAST_IDX;
            grant_idx <= '0;
            tmo_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) begin
                grant_idx <= winner;
                rr_ptr    <= winner;
            end
            if (state == SETUP)
                tmo_cnt <= '0;
            else if (state == ACCESS && !s_pready && tmo_cnt != TMO_LAST)
                tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    genvar i;
    generate
        for (i = 0; i < NUM_MASTERS; i++) begin : g_lane
            assign paddr_a[i]  = m_paddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            assign pwdata_a[i] = m_pwdata[i*DATA_WIDTH +: DATA_WIDTH];
            assign pstrb_a[i]  = m_pstrb[i*STRB_W +: STRB_W];
            assign pprot_a[i]  = m_pprot[i*3 +: 3];

            apb_arbiter_rr_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
                .sel       (grant_idx == IDX_W'(i)),
                .done      (done),
                .tmo       (tmo_hit),
                .s_prdata  (s_prdata),
                .s_pslverr (s_pslverr),
                .pready    (m_pready[i]),
                .prdata    (m_prdata[i*DATA_WIDTH +: DATA_WIDTH]),
                .pslverr   (m_pslverr[i])
            );
        end
    endgenerate

    // Payload is forced to zero outside a transfer so the slave bus idles clean.
    assign busy        = (state != IDLE);
    assign s_psel      = busy;
    assign s_penable   = (state == ACCESS);
    assign s_pwrite    = busy & m_pwrite[grant_idx];
    assign s_paddr     = busy ? paddr_a[grant_idx]  : '0;
    assign s_pwdata    = busy ? pwdata_a[grant_idx] : '0;
    assign s_pstrb     = busy ? pstrb_a[grant_idx]  : '0;
    assign s_pprot     = busy ? pprot_a[grant_idx]  : '0;
    assign timeout_err = tmo_hit;
endmodule
